// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// Module   : parking_gate_arbiter
// Purpose  : Shared barrier-gate controller and slot-occupancy map for a
//            car park. Arbitrates entry/exit requests (exit wins ties),
//            allocates the lowest free slot on entry, frees the named slot
//            on exit, then holds the gate open for GATE_CYCLES cycles.
// Options  : PARKING_FREE_COUNT_EN - adds the free_count output, a
//            registered up/down count of free slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_W      = 3,
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 entry_ack,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 exit_ack,
    output logic                 reject,
    output logic                 gate_open,
    output logic [NUM_SLOTS-1:0] slot_free,
    output logic                 full
`ifdef PARKING_FREE_COUNT_EN
    ,
    output logic [SLOT_W:0]      free_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_REJ   = 3'd2,
        S_OPEN  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   serve_exit_q;   // lane being served: 1 = exit, 0 = entry
    logic [SLOT_W-1:0]      idx_q;          // slot index latched at arbitration
    logic [7:0]             timer_q;
    logic                   entry_ack_q;
    logic                   exit_ack_q;
    logic                   reject_q;
    logic                   gate_open_q;
    logic [SLOT_W-1:0]      assigned_slot_q;
    logic [NUM_SLOTS-1:0]   slot_free_q;
    logic [NUM_SLOTS-1:0]   slot_free_d;
    logic                   full_q;
    logic [SLOT_W-1:0]      lowest_free;
    logic                   exit_in_range;
    logic                   exit_occupied;

    // Lowest-index free slot; scanning downward lets the smallest index win.
    always_comb begin
        lowest_free = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_free_q[i]) begin
                lowest_free = SLOT_W'(i);
            end
        end
    end

    // An exit is only valid for an in-range slot that is currently occupied.
    assign exit_in_range = (32'(exit_slot) < NUM_SLOTS);
    assign exit_occupied = exit_in_range && !slot_free_q[exit_slot];

    // Next occupancy map: only the GRANT cycle touches the latched slot bit.
    always_comb begin
        slot_free_d = slot_free_q;
        if (state_q == S_GRANT) begin
            slot_free_d[idx_q] = serve_exit_q;
        end
    end

`ifdef PARKING_FREE_COUNT_EN
    logic [SLOT_W:0] free_count_q;
    logic [SLOT_W:0] free_count_d;

    // Free-slot counter tracks the map incrementally, in step with slot_free.
    always_comb begin
        free_count_d = free_count_q;
        if (state_q == S_GRANT) begin
            if (serve_exit_q) begin
                free_count_d = free_count_q + 1'b1;
            end else begin
                free_count_d = free_count_q - 1'b1;
            end
        end
    end

    // Counter register; reset restores the all-free count.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_count_q <= (SLOT_W + 1)'(NUM_SLOTS);
        end else begin
            free_count_q <= free_count_d;
        end
    end

    assign free_count = free_count_q;
`endif

    // Arbitration FSM with registered acks, gate command and occupancy map.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            serve_exit_q    <= 1'b0;
            idx_q           <= '0;
            timer_q         <= '0;
            entry_ack_q     <= 1'b0;
            exit_ack_q      <= 1'b0;
            reject_q        <= 1'b0;
            gate_open_q     <= 1'b0;
            assigned_slot_q <= '0;
            slot_free_q     <= '1;
            full_q          <= 1'b0;
        end else begin
            entry_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            reject_q    <= 1'b0;
            slot_free_q <= slot_free_d;
            full_q      <= (slot_free_d == '0);
            case (state_q)
                S_IDLE: begin
                    if (exit_req) begin
                        serve_exit_q <= 1'b1;
                        idx_q        <= exit_slot;
                        if (exit_occupied) begin
                            exit_ack_q <= 1'b1;
                            state_q    <= S_GRANT;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= S_REJ;
                        end
                    end else if (entry_req) begin
                        serve_exit_q <= 1'b0;
                        idx_q        <= lowest_free;
                        if (slot_free_q != '0) begin
                            entry_ack_q     <= 1'b1;
                            assigned_slot_q <= lowest_free;
                            state_q         <= S_GRANT;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= S_REJ;
                        end
                    end
                end
                S_GRANT: begin
                    gate_open_q <= 1'b1;
                    timer_q     <= 8'(GATE_CYCLES);
                    state_q     <= S_OPEN;
                end
                S_REJ: begin
                    state_q <= S_CLEAR;
                end
                S_OPEN: begin
                    if (timer_q == 8'd1) begin
                        gate_open_q <= 1'b0;
                        state_q     <= S_CLEAR;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                S_CLEAR: begin
                    // Only the served lane releases us, so a held request
                    // cannot be granted twice.
                    if (serve_exit_q ? !exit_req : !entry_req) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign entry_ack     = entry_ack_q;
    assign exit_ack      = exit_ack_q;
    assign reject        = reject_q;
    assign gate_open     = gate_open_q;
    assign assigned_slot = assigned_slot_q;
    assign slot_free     = slot_free_q;
    assign full          = full_q;

endmodule

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Purpose  : Directed self-checking bench for parking_gate_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic       entry_ack;
    logic [2:0] assigned_slot;
    logic       exit_ack;
    logic       reject;
    logic       gate_open;
    logic [7:0] slot_free;
    logic       full;
`ifdef PARKING_FREE_COUNT_EN
    logic [3:0] free_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    parking_gate_arbiter #(
        .NUM_SLOTS   (8),
        .SLOT_W      (3),
        .GATE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .entry_ack     (entry_ack),
        .assigned_slot (assigned_slot),
        .exit_ack      (exit_ack),
        .reject        (reject),
        .gate_open     (gate_open),
        .slot_free     (slot_free),
        .full          (full)
`ifdef PARKING_FREE_COUNT_EN
        ,
        .free_count    (free_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 3'd0;
        settle(2);
        reset = 1'b0;
    endtask

    // Raise one lane's request until an ack/reject is seen (bounded), then drop it.
    task automatic req_pass(input bit is_exit, input logic [2:0] slot_in,
                            output bit acked, output bit rejected,
                            output logic [2:0] aslot);
        acked    = 1'b0;
        rejected = 1'b0;
        aslot    = 3'd0;
        if (is_exit) begin
            exit_req  = 1'b1;
            exit_slot = slot_in;
        end else begin
            entry_req = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (entry_ack === 1'b1 || exit_ack === 1'b1) begin
                acked = 1'b1;
                aslot = assigned_slot;
                break;
            end
            if (reject === 1'b1) begin
                rejected = 1'b1;
                break;
            end
        end
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({slot_free, full, gate_open, entry_ack, exit_ack, reject, assigned_slot} !== {8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL reset_state: got free=%h full=%b gate=%b ea=%b xa=%b rej=%b as=%0d, want free=ff full=0 gate=0 ea=0 xa=0 rej=0 as=0",
                     slot_free, full, gate_open, entry_ack, exit_ack, reject, assigned_slot);
        end
`ifdef PARKING_FREE_COUNT_EN
        n_cmp++;
        if (free_count !== 4'd8) begin
            n_err++;
            $display("FAIL reset_free_count: got %0d want 8", free_count);
        end
`endif
    endtask

    task automatic test_single_entry();
        bit acked, rejected;
        logic [2:0] aslot;
        int gate_hi;
        do_reset();
        step();
        entry_req = 1'b1;
        step();  // edge N samples the request
        n_cmp++;
        if (entry_ack !== 1'b1 || assigned_slot !== 3'd0 || slot_free !== 8'hFF) begin
            n_err++;
            $display("FAIL entry_ack_latency: got ack=%b slot=%0d free=%h, want ack=1 slot=0 free=ff",
                     entry_ack, assigned_slot, slot_free);
        end
        entry_req = 1'b0;
        step();  // cycle N+2
        n_cmp++;
        if (slot_free !== 8'hFE || entry_ack !== 1'b0 || gate_open !== 1'b1) begin
            n_err++;
            $display("FAIL entry_map_update: got free=%h ack=%b gate=%b, want free=fe ack=0 gate=1",
                     slot_free, entry_ack, gate_open);
        end
`ifdef PARKING_FREE_COUNT_EN
        n_cmp++;
        if (free_count !== 4'd7) begin
            n_err++;
            $display("FAIL entry_free_count: got %0d want 7", free_count);
        end
`endif
        gate_hi = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (gate_open === 1'b1) gate_hi++;
        end
        n_cmp++;
        if (gate_hi !== 4) begin
            n_err++;
            $display("FAIL gate_duration: got %0d cycles want 4", gate_hi);
        end
        // A fresh request must be served, proving the FSM returned to IDLE.
        req_pass(1'b0, 3'd0, acked, rejected, aslot);
        n_cmp++;
        if (acked !== 1'b1 || aslot !== 3'd1) begin
            n_err++;
            $display("FAIL return_idle: got ack=%b slot=%0d want ack=1 slot=1", acked, aslot);
        end
        settle(7);
    endtask

    task automatic test_fill_and_reject();
        bit acked, rejected;
        logic [2:0] aslot;
        int gate_hi;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_pass(1'b0, 3'd0, acked, rejected, aslot);
            n_cmp++;
            if (acked !== 1'b1 || aslot !== 3'(i)) begin
                n_err++;
                $display("FAIL fill_slot_%0d: got ack=%b slot=%0d want ack=1 slot=%0d", i, acked, aslot, i);
            end
            settle(7);
        end
        n_cmp++;
        if (full !== 1'b1 || slot_free !== 8'h00) begin
            n_err++;
            $display("FAIL full_flag: got full=%b free=%h want full=1 free=00", full, slot_free);
        end
        req_pass(1'b0, 3'd0, acked, rejected, aslot);
        n_cmp++;
        if (rejected !== 1'b1 || acked !== 1'b0) begin
            n_err++;
            $display("FAIL full_reject: got rej=%b ack=%b want rej=1 ack=0", rejected, acked);
        end
        gate_hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gate_open !== 1'b0) gate_hi++;
        end
        n_cmp++;
        if (gate_hi !== 0 || slot_free !== 8'h00) begin
            n_err++;
            $display("FAIL full_reject_gate: got gate_cycles=%0d free=%h want 0 and 00", gate_hi, slot_free);
        end
    endtask

    task automatic test_exit_priority();
        bit got_entry;
        // Map is 00 here; both lanes request together.
        exit_slot = 3'd5;
        exit_req  = 1'b1;
        entry_req = 1'b1;
        step();
        n_cmp++;
        if (exit_ack !== 1'b1 || entry_ack !== 1'b0 || reject !== 1'b0) begin
            n_err++;
            $display("FAIL exit_priority: got xa=%b ea=%b rej=%b want xa=1 ea=0 rej=0", exit_ack, entry_ack, reject);
        end
        exit_req = 1'b0;
        step();
        n_cmp++;
        if (slot_free !== 8'h20 || full !== 1'b0) begin
            n_err++;
            $display("FAIL exit_map: got free=%h full=%b want free=20 full=0", slot_free, full);
        end
        got_entry = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (entry_ack === 1'b1) begin
                got_entry = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (got_entry !== 1'b1 || assigned_slot !== 3'd5) begin
            n_err++;
            $display("FAIL deferred_entry: got ack_seen=%b slot=%0d want 1 and 5", got_entry, assigned_slot);
        end
        entry_req = 1'b0;
        step();
        n_cmp++;
        if (slot_free !== 8'h00 || full !== 1'b1) begin
            n_err++;
            $display("FAIL deferred_entry_map: got free=%h full=%b want 00 and 1", slot_free, full);
        end
        settle(7);
    endtask

    task automatic test_exit_reject();
        bit acked, rejected;
        logic [2:0] aslot;
        int gate_hi;
        req_pass(1'b1, 3'd3, acked, rejected, aslot);
        settle(7);
        n_cmp++;
        if (acked !== 1'b1 || slot_free !== 8'h08) begin
            n_err++;
            $display("FAIL exit_slot3: got ack=%b free=%h want ack=1 free=08", acked, slot_free);
        end
        req_pass(1'b1, 3'd3, acked, rejected, aslot);
        gate_hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gate_open !== 1'b0) gate_hi++;
        end
        n_cmp++;
        if (rejected !== 1'b1 || acked !== 1'b0 || gate_hi !== 0 || slot_free !== 8'h08) begin
            n_err++;
            $display("FAIL exit_free_reject: got rej=%b ack=%b gate_cycles=%0d free=%h want 1 0 0 08",
                     rejected, acked, gate_hi, slot_free);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        bit rejected;
        // Map 08: one slot free; hold entry for 20 cycles.
        acks = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (entry_ack === 1'b1) acks++;
            if (reject === 1'b1) acks += 100;
        end
        n_cmp++;
        if (acks !== 1 || slot_free !== 8'h00) begin
            n_err++;
            $display("FAIL held_request: got acks=%0d free=%h want acks=1 free=00", acks, slot_free);
        end
        entry_req = 1'b0;
        settle(2);
        entry_req = 1'b1;
        rejected  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (reject === 1'b1) rejected = 1'b1;
        end
        entry_req = 1'b0;
        n_cmp++;
        if (rejected !== 1'b1) begin
            n_err++;
            $display("FAIL rerequest_served: got rej=%b want 1", rejected);
        end
        settle(4);
    endtask

    task automatic test_reset_mid_pass();
        bit acked, rejected;
        logic [2:0] aslot;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_pass(1'b0, 3'd0, acked, rejected, aslot);
            settle(7);
        end
        req_pass(1'b0, 3'd0, acked, rejected, aslot);
        step();
        n_cmp++;
        if (gate_open !== 1'b1 || slot_free !== 8'hF0) begin
            n_err++;
            $display("FAIL pre_reset_open: got gate=%b free=%h want gate=1 free=f0", gate_open, slot_free);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (gate_open !== 1'b0 || slot_free !== 8'hFF || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_pass: got gate=%b free=%h full=%b want 0 ff 0", gate_open, slot_free, full);
        end
`ifdef PARKING_FREE_COUNT_EN
        n_cmp++;
        if (free_count !== 4'd8) begin
            n_err++;
            $display("FAIL reset_mid_pass_count: got %0d want 8", free_count);
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = 3'd0;
        test_reset();
        test_single_entry();
        test_fill_and_reject();
        test_exit_priority();
        test_exit_reject();
        test_back_to_back();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
